// File: rtl/fifo_fwft2_rd_sched.sv
// Read scheduler for the dual-read-port FWFT activation FIFO: drains a per-job
// word count from each port and merges both round-robin onto one stream.
module fifo_fwft2_rd_sched #(
  parameter int DATA_WIDTH = 4,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    Reset,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    len,
  input  logic [1:0]              fifo_empty,
  input  logic [2*DATA_WIDTH-1:0] fifo_data,
  output logic [1:0]              fifo_pop,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_port,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [LEN_WIDTH-1:0] cnt0_q, cnt1_q;
  logic [LEN_WIDTH-1:0] cnt0_d, cnt1_d;
  logic                 rr_last_q;
  logic                 hold_q;
  logic                 grant_q;
  logic                 busy_q;
  logic                 done_q;

  logic                  run;
  logic [1:0]            elig;
  logic                  grant;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] sel_data;

  assign run     = (state_q == S_RUN);
  assign elig[0] = run && (cnt0_q != '0) && !fifo_empty[0];
  assign elig[1] = run && (cnt1_q != '0) && !fifo_empty[1];

  // A held grant wins; otherwise the port that did not transfer last is preferred.
  always_comb begin
    grant = 1'b0;
    if (hold_q) begin
      grant = grant_q;
    end else if (rr_last_q) begin
      grant = !elig[0] && elig[1];
    end else begin
      grant = elig[1];
    end
  end

  // Valid/ready: a word moves when out_valid && out_ready at a rising edge; once
  // out_valid rises, valid, data and port stay fixed until that transfer.
  assign out_valid = run && (hold_q || (|elig));
  assign xfer      = out_valid && out_ready;
  assign fifo_pop  = xfer ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign sel_data  = grant ? fifo_data[2*DATA_WIDTH-1:DATA_WIDTH] : fifo_data[DATA_WIDTH-1:0];
  assign out_data  = out_valid ? sel_data : '0;
  assign out_port  = out_valid && grant;

  assign cnt0_d = cnt0_q - {{(LEN_WIDTH-1){1'b0}}, (xfer && !grant)};
  assign cnt1_d = cnt1_q - {{(LEN_WIDTH-1){1'b0}}, (xfer && grant)};

  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
      rr_last_q <= 1'b1;
      hold_q    <= 1'b0;
      grant_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (Reset) begin
      state_q   <= S_IDLE;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
      rr_last_q <= 1'b1;
      hold_q    <= 1'b0;
      grant_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt0_q  <= len;
            cnt1_q  <= len;
            state_q <= S_RUN;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          cnt0_q  <= cnt0_d;
          cnt1_q  <= cnt1_d;
          grant_q <= grant;
          if (xfer) begin
            rr_last_q <= grant;
            hold_q    <= 1'b0;
          end else if (out_valid) begin
            hold_q <= 1'b1;
          end
          if ((cnt0_d == '0) && (cnt1_d == '0)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_fwft2_rd_sched.sv
// Bench for fifo_fwft2_rd_sched: FIFO queues feed the DUT, a job-level model
// predicts every cycle, plus a vector table and directed corner sequences.
module tb_fifo_fwft2_rd_sched;
  localparam int DW = 4;
  localparam int LW = 8;
  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_DONE = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          Reset;
  logic          start;
  logic [LW-1:0] len;
  logic [1:0]    fifo_empty;
  logic [2*DW-1:0] fifo_data;
  logic [1:0]    fifo_pop;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_port;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  fifo_fwft2_rd_sched #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .Reset(Reset), .start(start), .len(len),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_pop(fifo_pop),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_port(out_port), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int pops0, pops1, done_cnt, busy_cnt;
  logic [1:0] pop_seen;

  // Job-level reference: phase, words still owed per port, last served port, pending offer.
  int m_phase;
  int m_rem[2];
  int m_last;
  bit m_hold;
  int m_hold_port;
  bit e_valid;
  int e_port;
  logic [DW-1:0] e_data;
  logic [1:0] e_pop;

  typedef struct {
    logic          rdy;
    logic          v;
    logic [DW-1:0] d;
    logic          p;
    logic [1:0]    pop;
    logic          b;
    logic          dn;
  } vec_t;
  vec_t tbl[8];

  function automatic vec_t mkvec(input logic rdy, input logic v, input logic [DW-1:0] d,
                                 input logic p, input logic [1:0] pop, input logic b,
                                 input logic dn);
    vec_t r;
    r.rdy = rdy; r.v = v; r.d = d; r.p = p; r.pop = pop; r.b = b; r.dn = dn;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh_fifo();
    fifo_empty[0] = (q0.size() == 0);
    fifo_empty[1] = (q1.size() == 0);
    fifo_data[DW-1:0]    = (q0.size() != 0) ? q0[0] : '0;
    fifo_data[2*DW-1:DW] = (q1.size() != 0) ? q1[0] : '0;
  endtask

  task automatic clear_fifo();
    q0.delete();
    q1.delete();
    exp_q.delete();
    refresh_fifo();
  endtask

  task automatic model_reset();
    m_phase = P_IDLE;
    m_rem[0] = 0;
    m_rem[1] = 0;
    m_last = 1;
    m_hold = 1'b0;
    m_hold_port = 0;
  endtask

  task automatic model_eval();
    bit av0, av1;
    e_valid = 1'b0;
    e_port  = 0;
    e_data  = '0;
    e_pop   = 2'b00;
    if (m_phase == P_RUN) begin
      av0 = (m_rem[0] > 0) && (q0.size() != 0);
      av1 = (m_rem[1] > 0) && (q1.size() != 0);
      if (m_hold) begin
        e_valid = 1'b1;
        e_port  = m_hold_port;
      end else if (m_last == 1) begin
        if (av0) begin e_valid = 1'b1; e_port = 0; end
        else if (av1) begin e_valid = 1'b1; e_port = 1; end
      end else begin
        if (av1) begin e_valid = 1'b1; e_port = 1; end
        else if (av0) begin e_valid = 1'b1; e_port = 0; end
      end
      if (e_valid) begin
        if (e_port == 1) e_data = (q1.size() != 0) ? q1[0] : '0;
        else             e_data = (q0.size() != 0) ? q0[0] : '0;
        if (out_ready) e_pop = (e_port == 1) ? 2'b10 : 2'b01;
      end
    end
  endtask

  task automatic model_update();
    if (!rst_n || Reset) begin
      model_reset();
    end else if (m_phase == P_IDLE) begin
      if (start) begin
        m_rem[0] = int'(len);
        m_rem[1] = int'(len);
        m_phase = P_RUN;
      end
    end else if (m_phase == P_RUN) begin
      if (e_valid && out_ready) begin
        m_rem[e_port] = m_rem[e_port] - 1;
        m_last = e_port;
        m_hold = 1'b0;
      end else if (e_valid) begin
        m_hold = 1'b1;
        m_hold_port = e_port;
      end
      if (m_rem[0] == 0 && m_rem[1] == 0) m_phase = P_DONE;
    end else begin
      m_phase = P_IDLE;
    end
  endtask

  task automatic sample_cycle();
    @(negedge clk);
    model_eval();
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    chk("out_port", 32'(out_port), e_valid ? 32'(e_port) : 32'd0);
    chk("out_data", 32'(out_data), 32'(e_data));
    chk("fifo_pop", 32'(fifo_pop), 32'(e_pop));
    chk("busy", 32'(busy), 32'(m_phase != P_IDLE));
    chk("done", 32'(done), 32'(m_phase == P_DONE));
    if (out_valid && out_ready && exp_q.size() != 0) chk("sb_order", 32'(out_data), 32'(exp_q.pop_front()));
    pop_seen = fifo_pop;
    pops0 += int'(fifo_pop[0]);
    pops1 += int'(fifo_pop[1]);
    done_cnt += int'(done);
    busy_cnt += int'(busy);
  endtask

  task automatic advance_cycle();
    @(posedge clk);
    model_update();
    if (pop_seen[0] && q0.size() != 0) void'(q0.pop_front());
    if (pop_seen[1] && q1.size() != 0) void'(q1.pop_front());
    #1;
    refresh_fifo();
  endtask

  task automatic tick();
    sample_cycle();
    advance_cycle();
  endtask

  task automatic clear_counts();
    pops0 = 0; pops1 = 0; done_cnt = 0; busy_cnt = 0;
  endtask

  task automatic start_job(input logic [LW-1:0] n);
    len = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] seq_d[6];
    int k;
    int d0;
    seq_d = '{4'h1, 4'h9, 4'h2, 4'hA, 4'h3, 4'hB};
    for (int i = 0; i < 6; i++)
      tbl[i] = mkvec(1'b1, 1'b1, seq_d[i], 1'(i % 2), (i % 2 == 1) ? 2'b10 : 2'b01, 1'b1, 1'b0);
    tbl[6] = mkvec(1'b1, 1'b0, 4'h0, 1'b0, 2'b00, 1'b1, 1'b1);
    tbl[7] = mkvec(1'b1, 1'b0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);

    rst_n = 1'b0; Reset = 1'b0; start = 1'b0; len = '0; out_ready = 1'b0;
    pop_seen = 2'b00;
    clear_counts();
    clear_fifo();
    model_reset();
    repeat (2) tick();
    chk("reset_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic interleave through the vector table
    q0 = '{4'h1, 4'h2, 4'h3};
    q1 = '{4'h9, 4'hA, 4'hB};
    refresh_fifo();
    out_ready = 1'b1;
    clear_counts();
    start_job(8'd3);
    exp_q = '{4'h1, 4'h9, 4'h2, 4'hA, 4'h3, 4'hB};
    for (int i = 0; i < 8; i++) begin
      out_ready = tbl[i].rdy;
      sample_cycle();
      chk("tbl_valid", 32'(out_valid), 32'(tbl[i].v));
      chk("tbl_data", 32'(out_data), 32'(tbl[i].d));
      chk("tbl_port", 32'(out_port), 32'(tbl[i].p));
      chk("tbl_pop", 32'(fifo_pop), 32'(tbl[i].pop));
      chk("tbl_busy", 32'(busy), 32'(tbl[i].b));
      chk("tbl_done", 32'(done), 32'(tbl[i].dn));
      advance_cycle();
    end
    chk("basic_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("basic_pops0", 32'(pops0), 32'd3);
    chk("basic_pops1", 32'(pops1), 32'd3);
    chk("basic_done_cnt", 32'(done_cnt), 32'd1);

    // Starved port1
    clear_fifo();
    clear_counts();
    q0 = '{4'h4, 4'h5};
    refresh_fifo();
    start_job(8'd2);
    repeat (5) tick();
    chk("starved_busy", 32'(busy), 32'd1);
    chk("starved_pops0", 32'(pops0), 32'd2);
    q1.push_back(4'h6);
    q1.push_back(4'h7);
    refresh_fifo();
    exp_q = '{4'h6, 4'h7};
    d0 = done_cnt;
    k = 0;
    while (done_cnt == d0 && k < 10) begin tick(); k++; end
    chk("starved_done", 32'(done_cnt - d0), 32'd1);
    chk("starved_sb_empty", 32'(exp_q.size()), 32'd0);
    tick();

    // Backpressure on the first word, port1 shows up mid-stall
    clear_fifo();
    clear_counts();
    q0.push_back(4'hC);
    refresh_fifo();
    out_ready = 1'b0;
    start_job(8'd1);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin q1.push_back(4'hD); refresh_fifo(); end
      sample_cycle();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'hC);
      chk("bp_port", 32'(out_port), 32'd0);
      chk("bp_pop", 32'(fifo_pop), 32'd0);
      advance_cycle();
    end
    out_ready = 1'b1;
    exp_q = '{4'hC, 4'hD};
    repeat (4) tick();
    chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("bp_done_cnt", 32'(done_cnt), 32'd1);

    // len == 0
    clear_fifo();
    clear_counts();
    start_job(8'd0);
    repeat (4) tick();
    chk("len0_busy", 32'(busy_cnt), 32'd2);
    chk("len0_done", 32'(done_cnt), 32'd1);
    chk("len0_pops", 32'(pops0 + pops1), 32'd0);

    // start during RUN is ignored
    clear_counts();
    q0 = '{4'h1, 4'h2};
    q1 = '{4'h3, 4'h4};
    refresh_fifo();
    exp_q = '{4'h1, 4'h3, 4'h2, 4'h4};
    start_job(8'd2);
    tick();
    len = 8'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("ign_pops0", 32'(pops0), 32'd2);
    chk("ign_pops1", 32'(pops1), 32'd2);
    chk("ign_done", 32'(done_cnt), 32'd1);
    chk("ign_sb_empty", 32'(exp_q.size()), 32'd0);

    // Synchronous Reset mid-job
    clear_fifo();
    clear_counts();
    q0 = '{4'h1, 4'h2, 4'h3};
    q1 = '{4'h9, 4'hA, 4'hB};
    refresh_fifo();
    start_job(8'd3);
    repeat (2) tick();
    out_ready = 1'b0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    out_ready = 1'b1;
    sample_cycle();
    chk("srst_state", 32'(dbg_state), 32'd0);
    chk("srst_valid", 32'(out_valid), 32'd0);
    advance_cycle();
    chk("srst_no_done", 32'(done_cnt), 32'd0);
    exp_q = '{4'h2, 4'hA};
    start_job(8'd1);
    repeat (4) tick();
    chk("srst_sb_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous rst_n mid-job, between clock edges
    clear_fifo();
    clear_counts();
    q0 = '{4'h1, 4'h2, 4'h3};
    q1 = '{4'h9, 4'hA, 4'hB};
    refresh_fifo();
    start_job(8'd3);
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_pop", 32'(fifo_pop), 32'd0);
    chk("arst_state", 32'(dbg_state), 32'd0);
    model_reset();
    pop_seen = 2'b00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    exp_q = '{4'h2};
    start_job(8'd1);
    repeat (4) tick();
    chk("arst_sb_empty", 32'(exp_q.size()), 32'd0);

    // Randomized traffic against the model
    clear_fifo();
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0 && q0.size() < 6) q0.push_back(DW'($urandom));
      if ($urandom_range(0, 2) == 0 && q1.size() < 6) q1.push_back(DW'($urandom));
      start = ($urandom_range(0, 7) == 0);
      len = LW'($urandom_range(0, 5));
      Reset = ($urandom_range(0, 99) == 0);
      refresh_fifo();
      tick();
    end
    Reset = 1'b0;
    start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
